wbxbc_req_slice: RTL and testbench
==================================

WBXBC_REQ_SLICE -- requirements
Module: wbxbc_req_slice

Interface
REQ-001 Parameters SHALL be ADR_WIDTH 16, DAT_WIDTH 16, SEL_WIDTH 2, TGA_WIDTH 1, TGC_WIDTH 1, TGRD_WIDTH 1 and TGWD_WIDTH 1, each the width of the matching bus or tag.
REQ-002 Parameter OUT_MAX SHALL default to 15 and set the maximum number of target accesses awaiting termination.
REQ-003 clk_i  in  1  clock; async_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 sync_rst_i  in  1  synchronous reset, active-high.
REQ-005 itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i  in  1 each  initiator cycle, strobe, write enable and lock.
REQ-006 itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i  in  SEL/ADR/DAT/TGA/TGC/TGWD  initiator request payload.
REQ-007 itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o  out  1 each; itr_dat_o  out  DAT; itr_tgd_o  out  TGRD.
REQ-008 tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o  out  1 each; tgt_sel/adr/dat/tga/tgc/tgd_o  out  payload widths.
REQ-009 tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i  in  1 each; tgt_dat_i  in  DAT; tgt_tgd_i  in  TGRD.

Function
REQ-010 Initiator accept SHALL be itr_cyc_i & itr_stb_i & ~itr_stall_o; the accepted request (we, lock, sel, adr, dat, tga, tgc, tgd) is pushed into a 2-entry FIFO.
REQ-011 itr_stall_o SHALL be a registered output, high exactly when the FIFO holds 2 entries.
REQ-012 tgt_stb_o SHALL be high when the FIFO is non-empty, itr_cyc_i is high and the outstanding count is below OUT_MAX; the payload outputs SHALL show the FIFO head.
REQ-013 The FIFO head SHALL pop when tgt_stb_o & ~tgt_stall_i; push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-014 Without bypass, a request accepted in cycle n SHALL first appear on tgt_stb_o in cycle n+1.
REQ-015 A 4-bit outstanding counter SHALL increment on a pop and decrement on tgt_ack_i|tgt_err_i|tgt_rty_i; a pop and a termination in the same cycle SHALL leave it unchanged.
REQ-016 tgt_cyc_o SHALL equal itr_cyc_i & (FIFO non-empty | outstanding count non-zero | itr_stb_i).
REQ-017 tgt_lock_o SHALL follow itr_lock_i while tgt_cyc_o is high.
REQ-018 itr_ack_o, itr_err_o, itr_rty_o, itr_dat_o and itr_tgd_o SHALL pass combinationally from tgt_*_i, with terminations gated by itr_cyc_i.
REQ-019 Deassertion of itr_cyc_i SHALL, on the next clock edge, empty the FIFO, clear the outstanding counter and drop itr_stall_o.
REQ-020 A termination while the outstanding count is 0 SHALL be ignored; the counter SHALL NOT wrap below 0 or above OUT_MAX.
REQ-021 tb-visible state SHALL use three states: IDLE (empty, count 0), BUSY (otherwise, FIFO not full) and FULL (2 entries).

Reset
REQ-022 async_rst_i or sync_rst_i SHALL empty the FIFO, clear the counter and enter IDLE.
REQ-023 In reset, itr_stall_o, tgt_cyc_o and tgt_stb_o SHALL be 0, and payload registers SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard all buffered and outstanding requests without emitting a termination.

Configuration
REQ-025 With WBXBC_REQ_SLICE_BYPASS_EN defined, an accept into an empty FIFO while the target does not stall SHALL drive tgt_stb_o and the payload combinationally in the same cycle, without a push.
REQ-026 Without WBXBC_REQ_SLICE_BYPASS_EN, all target request outputs SHALL come from registers, per REQ-014.

Structure
REQ-027 Package wbxbc_pkg SHALL hold the state enum (IDLE, BUSY, FULL) and the FIFO depth constant 2.
REQ-028 The 2-entry FIFO SHALL be sub-module wbxbc_req_fifo, parameterised by payload width.

Verification
REQ-029 Single read: accept adr 0x1234, we 0, tgt_stall_i 0 -> tgt_stb_o at n+1 with adr 0x1234; tgt_ack_i with dat 0xBEEF -> itr_ack_o 1 and itr_dat_o 0xBEEF in the same cycle.
REQ-030 Backpressure: tgt_stall_i held 1 while accepting 3 requests -> itr_stall_o 1 after 2 accepts; the third request is held until the first pop.
REQ-031 Outstanding limit: OUT_MAX 2, no terminations -> tgt_stb_o drops after 2 pops; one tgt_ack_i -> one further pop.
REQ-032 Abort: itr_cyc_i drops with 2 entries buffered and count 1 -> next cycle tgt_cyc_o 0, itr_stall_o 0, IDLE.
REQ-033 Async reset pulse mid-burst -> all outputs 0 immediately; no itr_ack_o after release.
REQ-034 Bypass build: empty FIFO, accept with tgt_stall_i 0 -> tgt_stb_o and adr in the same cycle; wb_pass_through assertions hold throughout.

Source files
------------

// File: rtl/wbxbc_pkg.sv
// rtl/wbxbc_pkg.sv - shared state encoding and buffer depth for the request slice
package wbxbc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/wbxbc_req_fifo.sv
// rtl/wbxbc_req_fifo.sv - two-entry request FIFO, payload width set by WIDTH
module wbxbc_req_fifo
  import wbxbc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               async_rst_i,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   head_o,
  output logic [FIFO_CW-1:0] cnt_o
);

  logic [WIDTH-1:0]   ent0_q, ent1_q;
  logic               rd_q, wr_q;
  logic [FIFO_CW-1:0] cnt_q;

  // clr_i also zeroes the entries so a cleared slice shows an all-zero payload
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        if (wr_q) ent1_q <= data_i;
        else      ent0_q <= data_i;
        wr_q <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      if (push_i && !pop_i)      cnt_q <= cnt_q + FIFO_CW'(1);
      else if (pop_i && !push_i) cnt_q <= cnt_q - FIFO_CW'(1);
    end
  end

  assign head_o = rd_q ? ent1_q : ent0_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/wbxbc_req_slice.sv
// rtl/wbxbc_req_slice.sv - pipelined Wishbone request slice; WBXBC_REQ_SLICE_BYPASS_EN enables empty-FIFO bypass
module wbxbc_req_slice
  import wbxbc_pkg::*;
#(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGRD_WIDTH = 1,
  parameter int TGWD_WIDTH = 1,
  parameter int OUT_MAX    = 15
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sync_rst_i,
  input  logic                  itr_cyc_i,
  input  logic                  itr_stb_i,
  input  logic                  itr_we_i,
  input  logic                  itr_lock_i,
  input  logic [SEL_WIDTH-1:0]  itr_sel_i,
  input  logic [ADR_WIDTH-1:0]  itr_adr_i,
  input  logic [DAT_WIDTH-1:0]  itr_dat_i,
  input  logic [TGA_WIDTH-1:0]  itr_tga_i,
  input  logic [TGC_WIDTH-1:0]  itr_tgc_i,
  input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
  output logic                  itr_ack_o,
  output logic                  itr_err_o,
  output logic                  itr_rty_o,
  output logic                  itr_stall_o,
  output logic [DAT_WIDTH-1:0]  itr_dat_o,
  output logic [TGRD_WIDTH-1:0] itr_tgd_o,
  output logic                  tgt_cyc_o,
  output logic                  tgt_stb_o,
  output logic                  tgt_we_o,
  output logic                  tgt_lock_o,
  output logic [SEL_WIDTH-1:0]  tgt_sel_o,
  output logic [ADR_WIDTH-1:0]  tgt_adr_o,
  output logic [DAT_WIDTH-1:0]  tgt_dat_o,
  output logic [TGA_WIDTH-1:0]  tgt_tga_o,
  output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
  output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  tgt_ack_i,
  input  logic                  tgt_err_i,
  input  logic                  tgt_rty_i,
  input  logic                  tgt_stall_i,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
  input  logic [TGRD_WIDTH-1:0] tgt_tgd_i
);

  localparam int PW = 1 + SEL_WIDTH + ADR_WIDTH + DAT_WIDTH + TGA_WIDTH + TGC_WIDTH + TGWD_WIDTH;

  state_t             state_q, state_d;
  logic [3:0]         out_cnt_q, out_cnt_d;
  logic [FIFO_CW-1:0] fifo_cnt, fifo_cnt_d;
  logic [PW-1:0]      itr_pl, fifo_head, req_out;
  logic in_rst, clr, accept, bypass, push, pop, issue, term, dec, fifo_empty, out_ok;

  assign in_rst     = async_rst_i | sync_rst_i;
  assign clr        = sync_rst_i | ~itr_cyc_i;
  assign fifo_empty = (fifo_cnt == '0);
  assign out_ok     = (out_cnt_q < 4'(OUT_MAX));
  assign accept     = itr_cyc_i & itr_stb_i & ~itr_stall_o;
  assign itr_pl     = {itr_we_i, itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i};

`ifdef WBXBC_REQ_SLICE_BYPASS_EN
  assign bypass  = accept & fifo_empty & out_ok & ~tgt_stall_i;
  assign req_out = bypass ? itr_pl : fifo_head;
`else
  assign bypass  = 1'b0;
  assign req_out = fifo_head;
`endif

  assign push  = accept & ~bypass;
  assign issue = tgt_stb_o & ~tgt_stall_i;
  assign pop   = issue & ~fifo_empty;
  assign term  = tgt_ack_i | tgt_err_i | tgt_rty_i;
  assign dec   = term & (out_cnt_q != 4'd0);

  wbxbc_req_fifo #(.WIDTH(PW)) u_fifo (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .clr_i       (clr),
    .push_i      (push),
    .data_i      (itr_pl),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .cnt_o       (fifo_cnt)
  );

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q   <= IDLE;
      out_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // state mirrors the registered occupancy so that FULL directly drives itr_stall_o
  always_comb begin
    fifo_cnt_d = fifo_cnt;
    out_cnt_d  = out_cnt_q;
    state_d    = state_q;
    if (clr) begin
      fifo_cnt_d = '0;
      out_cnt_d  = 4'd0;
    end else begin
      if (push && !pop)      fifo_cnt_d = fifo_cnt + FIFO_CW'(1);
      else if (pop && !push) fifo_cnt_d = fifo_cnt - FIFO_CW'(1);
      if (issue && !dec)      out_cnt_d = out_cnt_q + 4'd1;
      else if (dec && !issue) out_cnt_d = out_cnt_q - 4'd1;
    end
    if (fifo_cnt_d == FIFO_CW'(FIFO_DEPTH))             state_d = FULL;
    else if (fifo_cnt_d == '0 && out_cnt_d == 4'd0)     state_d = IDLE;
    else                                                state_d = BUSY;
  end

  assign itr_stall_o = (state_q == FULL) & ~in_rst;
  assign tgt_stb_o   = ~in_rst & itr_cyc_i & out_ok & (~fifo_empty | bypass);
  assign tgt_cyc_o   = ~in_rst & itr_cyc_i & (~fifo_empty | (out_cnt_q != 4'd0) | itr_stb_i);
  assign tgt_lock_o  = itr_lock_i & tgt_cyc_o;

  assign {tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o} = req_out;

  assign itr_ack_o = tgt_ack_i & itr_cyc_i & ~in_rst;
  assign itr_err_o = tgt_err_i & itr_cyc_i & ~in_rst;
  assign itr_rty_o = tgt_rty_i & itr_cyc_i & ~in_rst;
  assign itr_dat_o = tgt_dat_i;
  assign itr_tgd_o = tgt_tgd_i;

endmodule

// File: tb/tb_wbxbc_req_slice.sv
// tb/tb_wbxbc_req_slice.sv - directed self-checking bench for wbxbc_req_slice (OUT_MAX 2)
module tb_wbxbc_req_slice;
  import wbxbc_pkg::*;

  logic clk_i = 1'b0;
  logic async_rst_i, sync_rst_i;
  logic itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i;
  logic [1:0]  itr_sel_i;
  logic [15:0] itr_adr_i, itr_dat_i;
  logic [0:0]  itr_tga_i, itr_tgc_i, itr_tgd_i;
  logic itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o;
  logic [15:0] itr_dat_o;
  logic [0:0]  itr_tgd_o;
  logic tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o;
  logic [1:0]  tgt_sel_o;
  logic [15:0] tgt_adr_o, tgt_dat_o;
  logic [0:0]  tgt_tga_o, tgt_tgc_o, tgt_tgd_o;
  logic tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i;
  logic [15:0] tgt_dat_i;
  logic [0:0]  tgt_tgd_i;

  int n_cmp = 0;
  int n_err = 0;
  bit done  = 1'b0;

  always #5 clk_i = ~clk_i;

  wbxbc_req_slice #(.OUT_MAX(2)) dut (
    .clk_i(clk_i), .async_rst_i(async_rst_i), .sync_rst_i(sync_rst_i),
    .itr_cyc_i(itr_cyc_i), .itr_stb_i(itr_stb_i), .itr_we_i(itr_we_i), .itr_lock_i(itr_lock_i),
    .itr_sel_i(itr_sel_i), .itr_adr_i(itr_adr_i), .itr_dat_i(itr_dat_i),
    .itr_tga_i(itr_tga_i), .itr_tgc_i(itr_tgc_i), .itr_tgd_i(itr_tgd_i),
    .itr_ack_o(itr_ack_o), .itr_err_o(itr_err_o), .itr_rty_o(itr_rty_o), .itr_stall_o(itr_stall_o),
    .itr_dat_o(itr_dat_o), .itr_tgd_o(itr_tgd_o),
    .tgt_cyc_o(tgt_cyc_o), .tgt_stb_o(tgt_stb_o), .tgt_we_o(tgt_we_o), .tgt_lock_o(tgt_lock_o),
    .tgt_sel_o(tgt_sel_o), .tgt_adr_o(tgt_adr_o), .tgt_dat_o(tgt_dat_o),
    .tgt_tga_o(tgt_tga_o), .tgt_tgc_o(tgt_tgc_o), .tgt_tgd_o(tgt_tgd_o),
    .tgt_ack_i(tgt_ack_i), .tgt_err_i(tgt_err_i), .tgt_rty_i(tgt_rty_i), .tgt_stall_i(tgt_stall_i),
    .tgt_dat_i(tgt_dat_i), .tgt_tgd_i(tgt_tgd_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  // response pass-through is combinational and must hold on every cycle
  always @(negedge clk_i) begin
    if (!done) begin
      chk("pass_dat", 32'(itr_dat_o), 32'(tgt_dat_i));
      chk("pass_tgd", 32'(itr_tgd_o), 32'(tgt_tgd_i));
    end
  end

  initial begin
    async_rst_i = 1'b1; sync_rst_i = 1'b0;
    itr_cyc_i = 1'b0; itr_stb_i = 1'b0; itr_we_i = 1'b0; itr_lock_i = 1'b0;
    itr_sel_i = 2'd0; itr_adr_i = 16'h0; itr_dat_i = 16'h0;
    itr_tga_i = 1'b0; itr_tgc_i = 1'b0; itr_tgd_i = 1'b0;
    tgt_ack_i = 1'b0; tgt_err_i = 1'b0; tgt_rty_i = 1'b0; tgt_stall_i = 1'b0;
    tgt_dat_i = 16'h0; tgt_tgd_i = 1'b0;
    #3;
    chk("rst_stall", 32'(itr_stall_o), 32'd0);
    chk("rst_cyc",   32'(tgt_cyc_o),   32'd0);
    chk("rst_stb",   32'(tgt_stb_o),   32'd0);
    chk("rst_adr",   32'(tgt_adr_o),   32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    tick();
    async_rst_i = 1'b0;
    tick();

    // single read
    itr_cyc_i = 1'b1; itr_stb_i = 1'b1; itr_we_i = 1'b0; itr_sel_i = 2'd3; itr_adr_i = 16'h1234;
    look();
    chk("rd_accept", 32'(itr_stall_o), 32'd0);
    chk("rd_cyc_a",  32'(tgt_cyc_o),   32'd1);
`ifdef WBXBC_REQ_SLICE_BYPASS_EN
    chk("rd_stb_a",  32'(tgt_stb_o),   32'd1);
    chk("rd_adr_a",  32'(tgt_adr_o),   32'h1234);
`else
    chk("rd_stb_a",  32'(tgt_stb_o),   32'd0);
`endif
    tick();
    itr_stb_i = 1'b0;
    look();
`ifdef WBXBC_REQ_SLICE_BYPASS_EN
    chk("rd_stb_b",  32'(tgt_stb_o),   32'd0);
`else
    chk("rd_stb_b",  32'(tgt_stb_o),   32'd1);
    chk("rd_adr_b",  32'(tgt_adr_o),   32'h1234);
    chk("rd_we_b",   32'(tgt_we_o),    32'd0);
`endif
    tick();
    tgt_ack_i = 1'b1; tgt_dat_i = 16'hBEEF;
    look();
    chk("rd_ack",    32'(itr_ack_o),   32'd1);
    chk("rd_dat",    32'(itr_dat_o),   32'hBEEF);
    chk("rd_cyc_c",  32'(tgt_cyc_o),   32'd1);
    tick();
    tgt_ack_i = 1'b0;
    look();
    chk("rd_cyc_d",  32'(tgt_cyc_o),   32'd0);
    chk("rd_idle",   32'(dut.state_q), 32'(IDLE));

    // termination at zero outstanding must not wrap the counter
    tick();
    tgt_ack_i = 1'b1;
    tick();
    tgt_ack_i = 1'b0; itr_stb_i = 1'b1; itr_adr_i = 16'h0F0F;
    look();
`ifdef WBXBC_REQ_SLICE_BYPASS_EN
    chk("nowrap_stb", 32'(tgt_stb_o), 32'd1);
    tick();
    itr_stb_i = 1'b0;
`else
    tick();
    itr_stb_i = 1'b0;
    look();
    chk("nowrap_stb", 32'(tgt_stb_o), 32'd1);
    chk("nowrap_adr", 32'(tgt_adr_o), 32'h0F0F);
    tick();
`endif
    tgt_ack_i = 1'b1;
    tick();
    tgt_ack_i = 1'b0;
    look();
    chk("nowrap_idle", 32'(dut.state_q), 32'(IDLE));

    // backpressure then outstanding limit of 2
    tick();
    tgt_stall_i = 1'b1; itr_stb_i = 1'b1; itr_adr_i = 16'hA001;
    look();
    chk("bp_acc1", 32'(itr_stall_o), 32'd0);
    tick();
    itr_adr_i = 16'hA002;
    look();
    chk("bp_acc2", 32'(itr_stall_o), 32'd0);
    chk("bp_stb2", 32'(tgt_stb_o),   32'd1);
    chk("bp_adr2", 32'(tgt_adr_o),   32'hA001);
    tick();
    itr_adr_i = 16'hA003;
    look();
    chk("bp_full3", 32'(itr_stall_o), 32'd1);
    chk("bp_adr3",  32'(tgt_adr_o),   32'hA001);
    tick();
    tgt_stall_i = 1'b0;
    look();
    chk("bp_full4",  32'(itr_stall_o), 32'd1);
    chk("bp_state4", 32'(dut.state_q), 32'(FULL));
    tick();
    look();
    chk("bp_acc5", 32'(itr_stall_o), 32'd0);
    chk("bp_adr5", 32'(tgt_adr_o),   32'hA002);
    tick();
    itr_stb_i = 1'b0; tgt_ack_i = 1'b1;
    look();
    chk("lim_stb6", 32'(tgt_stb_o), 32'd0);
    chk("lim_adr6", 32'(tgt_adr_o), 32'hA003);
    chk("lim_ack6", 32'(itr_ack_o), 32'd1);
    tick();
    tgt_ack_i = 1'b0;
    look();
    chk("lim_stb7", 32'(tgt_stb_o), 32'd1);
    chk("lim_adr7", 32'(tgt_adr_o), 32'hA003);
    tick();
    look();
    chk("lim_stb8",   32'(tgt_stb_o),   32'd0);
    chk("lim_state8", 32'(dut.state_q), 32'(BUSY));
    tick();
    itr_cyc_i = 1'b0;
    look();
    chk("drop_cyc", 32'(tgt_cyc_o), 32'd0);
    tick();
    itr_cyc_i = 1'b1;
    look();
    chk("drop_clr_cyc", 32'(tgt_cyc_o),   32'd0);
    chk("drop_idle",    32'(dut.state_q), 32'(IDLE));

    // abort with buffered and outstanding requests
    tick();
    itr_stb_i = 1'b1; itr_adr_i = 16'hB001;
    tick();
    itr_adr_i = 16'hB002;
    tick();
    itr_adr_i = 16'hB003; tgt_stall_i = 1'b1;
    tick();
`ifndef WBXBC_REQ_SLICE_BYPASS_EN
    look();
    chk("ab_full", 32'(itr_stall_o), 32'd1);
`endif
    itr_cyc_i = 1'b0; itr_stb_i = 1'b0;
    tick();
    itr_cyc_i = 1'b1; tgt_stall_i = 1'b0;
    look();
    chk("ab_cyc",   32'(tgt_cyc_o),   32'd0);
    chk("ab_stall", 32'(itr_stall_o), 32'd0);
    chk("ab_stb",   32'(tgt_stb_o),   32'd0);
    chk("ab_idle",  32'(dut.state_q), 32'(IDLE));

    // synchronous reset
    tick();
    itr_stb_i = 1'b1; itr_adr_i = 16'hC001; tgt_stall_i = 1'b1;
    tick();
    sync_rst_i = 1'b1;
    look();
    chk("srst_stall", 32'(itr_stall_o), 32'd0);
    chk("srst_stb",   32'(tgt_stb_o),   32'd0);
    chk("srst_cyc",   32'(tgt_cyc_o),   32'd0);
    tick();
    sync_rst_i = 1'b0; itr_stb_i = 1'b0;
    look();
    chk("srst_post_stb", 32'(tgt_stb_o),   32'd0);
    chk("srst_post_cyc", 32'(tgt_cyc_o),   32'd0);
    chk("srst_idle",     32'(dut.state_q), 32'(IDLE));

    // asynchronous reset pulse mid-burst
    tick();
    itr_stb_i = 1'b1; itr_adr_i = 16'hD001; tgt_stall_i = 1'b1;
    tick();
    itr_adr_i = 16'hD002;
    tick();
    look();
    chk("arst_pre_full", 32'(itr_stall_o), 32'd1);
    async_rst_i = 1'b1;
    #1;
    chk("arst_cyc",   32'(tgt_cyc_o),   32'd0);
    chk("arst_stb",   32'(tgt_stb_o),   32'd0);
    chk("arst_stall", 32'(itr_stall_o), 32'd0);
    chk("arst_adr",   32'(tgt_adr_o),   32'h0);
    chk("arst_ack",   32'(itr_ack_o),   32'd0);
    async_rst_i = 1'b0; itr_stb_i = 1'b0; tgt_stall_i = 1'b0;
    tick();
    look();
    chk("arst_post_stb", 32'(tgt_stb_o),   32'd0);
    chk("arst_post_cyc", 32'(tgt_cyc_o),   32'd0);
    chk("arst_post_ack", 32'(itr_ack_o),   32'd0);
    chk("arst_idle",     32'(dut.state_q), 32'(IDLE));

    // termination gating by itr_cyc_i
    tick();
    itr_cyc_i = 1'b0; tgt_err_i = 1'b1; tgt_rty_i = 1'b1; tgt_dat_i = 16'h5A5A; tgt_tgd_i = 1'b1;
    look();
    chk("gate_err_off", 32'(itr_err_o), 32'd0);
    chk("gate_rty_off", 32'(itr_rty_o), 32'd0);
    tick();
    itr_cyc_i = 1'b1;
    look();
    chk("gate_err_on", 32'(itr_err_o), 32'd1);
    chk("gate_rty_on", 32'(itr_rty_o), 32'd1);
    tick();
    tgt_err_i = 1'b0; tgt_rty_i = 1'b0; itr_lock_i = 1'b1; itr_stb_i = 1'b1; itr_adr_i = 16'hE001;
    look();
    chk("lock_on", 32'(tgt_lock_o), 32'd1);
    itr_cyc_i = 1'b0;
    #1;
    chk("lock_off", 32'(tgt_lock_o), 32'd0);

    tick();
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
